// File: rtl/flash_pkg.sv
// Shared constants and state encoding for the SPI boot-flash read master.
package flash_pkg;

    localparam int         ADDR_W         = 24;
    localparam logic [7:0] CMD_READ       = 8'h03;
    localparam logic [7:0] CMD_RELEASE_PD = 8'hAB;

    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        CMD,
        ADDR,
        DATA,
        DESEL
    } flash_state_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: SCK divider plus one 8-bit shifter that transmits MSB first
// while capturing MISO on every SCK rising edge.
module spi_shift_engine
    import flash_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       load_i,
    input  logic [7:0] byte_i,
    input  logic       miso_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] byte_o,
    output logic       sck_o,
    output logic       mosi_o
);

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy_q;
    logic             sck_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic [7:0]       tx_q;
    logic [7:0]       rx_q;
    logic             phaseEnd;
    logic             byteDone;

    assign phaseEnd = busy_q && (div_q == DIV_LAST);
    // The last clock of the final high phase: a load seen here starts the next
    // byte's low phase immediately, so consecutive bytes run without gaps.
    assign byteDone = phaseEnd && sck_q && (bit_q == 3'd7);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            div_q  <= '0;
            bit_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else if (load_i && (!busy_q || byteDone)) begin
            busy_q <= 1'b1;
            sck_q  <= 1'b0;
            div_q  <= '0;
            bit_q  <= '0;
            tx_q   <= byte_i;
        end else if (busy_q) begin
            if (!phaseEnd) begin
                div_q <= div_q + 1'b1;
            end else begin
                div_q <= '0;
                if (!sck_q) begin
                    sck_q <= 1'b1;
                    rx_q  <= {rx_q[6:0], miso_i};
                end else begin
                    sck_q <= 1'b0;
                    if (bit_q == 3'd7) begin
                        busy_q <= 1'b0;
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        tx_q  <= {tx_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = byteDone;
    assign byte_o = rx_q;
    assign sck_o  = sck_q;
    assign mosi_o = busy_q & tx_q[7];

endmodule

// File: rtl/spi_flash_read_master.sv
// SPI flash read master: releases the flash from power-down once after reset, then
// serves 32-bit little-endian READ (0x03) fetches for ROM instruction and data access.
module spi_flash_read_master
    import flash_pkg::*;
#(
    parameter int CLK_DIV     = 1,
    parameter int WAKE_CYCLES = 64,
    parameter int CS_HIGH_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [31:0]       data_o,
    output logic              flash_csn,
    output logic              flash_clk,
    output logic              flash_mosi,
    input  logic              flash_miso,
    output logic              flash_wpn,
    output logic              flash_holdn
);

    localparam int               CNT_MAX    = (WAKE_CYCLES > CS_HIGH_CYC) ? WAKE_CYCLES : CS_HIGH_CYC;
    localparam int               CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DESEL_LAST = CNT_W'(CS_HIGH_CYC - 1);

    flash_state_t      state_q, state_d;
    logic              csn_q, csn_d;
    logic              ack_q, ack_d;
    logic [31:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [23:0]       rdBuf_q, rdBuf_d;
    logic [1:0]        byteCnt_q, byteCnt_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;

    logic       engLoad;
    logic [7:0] engTx;
    logic       engBusy;
    logic       engDone;
    logic [7:0] engRx;
    logic       engSck;
    logic       engMosi;

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (engLoad),
        .byte_i  (engTx),
        .miso_i  (flash_miso),
        .busy_o  (engBusy),
        .done_o  (engDone),
        .byte_o  (engRx),
        .sck_o   (engSck),
        .mosi_o  (engMosi)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= WAKE_CMD;
            csn_q     <= 1'b1;
            ack_q     <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            rdBuf_q   <= '0;
            byteCnt_q <= '0;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            csn_q     <= csn_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            rdBuf_q   <= rdBuf_d;
            byteCnt_q <= byteCnt_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Each byte hand-off happens on the engine's done cycle so the next byte's
    // first low phase follows the previous high phase without an idle clock.
    always_comb begin
        state_d   = state_q;
        csn_d     = csn_q;
        ack_d     = 1'b0;
        data_d    = data_q;
        addr_d    = addr_q;
        rdBuf_d   = rdBuf_q;
        byteCnt_d = byteCnt_q;
        waitCnt_d = waitCnt_q;
        engLoad   = 1'b0;
        engTx     = 8'h00;

        case (state_q)
            WAKE_CMD: begin
                engTx = CMD_RELEASE_PD;
                if (!engBusy) begin
                    engLoad = 1'b1;
                    csn_d   = 1'b0;
                end else if (engDone) begin
                    csn_d     = 1'b1;
                    waitCnt_d = '0;
                    state_d   = WAKE_WAIT;
                end
            end
            WAKE_WAIT: begin
                if (waitCnt_q == WAKE_LAST) begin
                    state_d = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (req_i) begin
                    addr_d  = addr_i;
                    engLoad = 1'b1;
                    engTx   = CMD_READ;
                    csn_d   = 1'b0;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (engDone) begin
                    engLoad   = 1'b1;
                    engTx     = addr_q[23:16];
                    byteCnt_d = '0;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (engDone) begin
                    engLoad = 1'b1;
                    if (byteCnt_q == 2'd2) begin
                        byteCnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        engTx     = (byteCnt_q == 2'd0) ? addr_q[15:8] : addr_q[7:0];
                        byteCnt_d = byteCnt_q + 2'd1;
                    end
                end
            end
            DATA: begin
                if (engDone) begin
                    if (byteCnt_q == 2'd3) begin
                        data_d    = {engRx, rdBuf_q};
                        ack_d     = 1'b1;
                        csn_d     = 1'b1;
                        waitCnt_d = '0;
                        state_d   = DESEL;
                    end else begin
                        case (byteCnt_q)
                            2'd0:    rdBuf_d[7:0]   = engRx;
                            2'd1:    rdBuf_d[15:8]  = engRx;
                            default: rdBuf_d[23:16] = engRx;
                        endcase
                        engLoad   = 1'b1;
                        byteCnt_d = byteCnt_q + 2'd1;
                    end
                end
            end
            DESEL: begin
                if (waitCnt_q == DESEL_LAST) begin
                    state_d = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = WAKE_CMD;
            end
        endcase
    end

    assign ready_o     = (state_q == IDLE);
    assign ack_o       = ack_q;
    assign data_o      = data_q;
    assign flash_csn   = csn_q;
    assign flash_clk   = engSck;
    assign flash_mosi  = engMosi;
    assign flash_wpn   = 1'b1;
    assign flash_holdn = 1'b1;

endmodule
